// File: rtl/cpu_isa_pkg.sv
// CR16-subset ISA constants shared by the control unit.
// Opcodes, condition codes, state and mux-select encodings.
package cpu_isa_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC      = 3'd2,
    S_MEM       = 3'd3,
    S_LOAD_WAIT = 3'd4
  } state_t;

  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_SPEC  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam logic       A_REG  = 1'b0;
  localparam logic       A_PC   = 1'b1;
  localparam logic [1:0] B_REG  = 2'd0;
  localparam logic [1:0] B_ZEXT = 2'd1;
  localparam logic [1:0] B_SEXT = 2'd2;
  localparam logic [1:0] B_ONE  = 2'd3;
  localparam logic       ALU_EXT = 1'b0;
  localparam logic       ALU_OP  = 1'b1;
  localparam logic [1:0] IT_RR  = 2'd0;
  localparam logic [1:0] IT_IMM = 2'd1;
  localparam logic [1:0] IT_BR  = 2'd2;
  localparam logic [1:0] RD_ALU = 2'd0;
  localparam logic [1:0] RD_MEM = 2'd1;
  localparam logic [1:0] RD_LUI = 2'd2;
  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_ALU = 2'd1;
  localparam logic [1:0] PC_REG = 2'd2;
  localparam logic       MA_REG = 1'b0;
  localparam logic       MA_PC  = 1'b1;

  localparam int F_C = 0;
  localparam int F_L = 1;
  localparam int F_F = 2;
  localparam int F_N = 3;
  localparam int F_Z = 4;

  function automatic logic is_alu_ext(input logic [3:0] ext);
    return ext inside {EXT_ADD, EXT_SUB, EXT_AND, EXT_OR,
                       EXT_XOR, EXT_MOV, EXT_CMP};
  endfunction

  function automatic logic is_imm_op(input logic [3:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_CMPI, OP_ANDI,
                      OP_ORI, OP_XORI, OP_MOVI};
  endfunction

  function automatic logic is_sext_op(input logic [3:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI};
  endfunction

endpackage

// File: rtl/cpu_control_fsm_cond_eval.sv
// Branch/jump condition evaluation against the latched PSR.
// Purely combinational.
module cond_eval
  import cpu_isa_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic c, l, f, n, z;

  assign c = flags[F_C];
  assign l = flags[F_L];
  assign f = flags[F_F];
  assign n = flags[F_N];
  assign z = flags[F_Z];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_HI: taken = l;
      CC_LS: taken = !l;
      CC_GT: taken = n;
      CC_LE: taken = !n;
      CC_FS: taken = f;
      CC_FC: taken = !f;
      CC_LO: taken = !l && !z;
      CC_HS: taken = l || z;
      CC_LT: taken = !n && !z;
      CC_GE: taken = n || z;
      CC_UC: taken = 1'b1;
      CC_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle control unit for the 16-bit CR16-subset CPU.
// Sequences fetch/decode/exec/memory and owns the PSR.
module cpu_control_fsm
  import cpu_isa_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STORE_HOLD  = 1,
  parameter int unsigned CNT_BITS    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [4:0]  alu_flags,
  output logic        ir_load,
  output logic        mux_a_sel,
  output logic [1:0]  mux_b_sel,
  output logic        alu_op_sel,
  output logic [1:0]  instr_type,
  output logic        rf_we,
  output logic [1:0]  rf_data_sel,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        mem_addr_sel,
  output logic        mem_we,
  output logic [4:0]  flags,
  output logic        illegal,
  output logic [2:0]  state_dbg
);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                cnt_inc;
  logic                armed_q, armed_d;
  logic [4:0]          flags_q;
  logic                taken;

  logic [3:0] op, cond, ext;
  logic is_rr, is_imm, is_lui, is_bcond;
  logic is_load, is_stor, is_jcond, is_exec;
  logic upd_cf, upd_lnz, last_lat, last_st;
  logic unused_rsrc;

  assign op   = instr[15:12];
  assign cond = instr[11:8];
  assign ext  = instr[7:4];
  assign unused_rsrc = ^instr[3:0];

  assign is_rr    = (op == OP_RR) && is_alu_ext(ext);
  assign is_imm   = is_imm_op(op);
  assign is_lui   = (op == OP_LUI);
  assign is_bcond = (op == OP_BCOND);
  assign is_load  = (op == OP_SPEC) && (ext == EXT_LOAD);
  assign is_stor  = (op == OP_SPEC) && (ext == EXT_STOR);
  assign is_jcond = (op == OP_SPEC) && (ext == EXT_JCOND);
  assign is_exec  = is_rr | is_imm | is_lui | is_bcond | is_jcond;

  assign upd_cf  = (is_rr && (ext == EXT_ADD || ext == EXT_SUB))
                 || op == OP_ADDI || op == OP_SUBI;
  assign upd_lnz = (is_rr && ext == EXT_CMP) || op == OP_CMPI;

  assign last_lat = (cnt_q == CNT_BITS'(MEM_LATENCY - 1));
  assign last_st  = (cnt_q == CNT_BITS'(STORE_HOLD - 1));

  cond_eval u_cond (
    .cond  (cond),
    .flags (flags_q),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      if (state_q == S_EXEC && upd_cf) begin
        flags_q[F_C] <= alu_flags[F_C];
        flags_q[F_F] <= alu_flags[F_F];
      end
      if (state_q == S_EXEC && upd_lnz) begin
        flags_q[F_L] <= alu_flags[F_L];
        flags_q[F_N] <= alu_flags[F_N];
        flags_q[F_Z] <= alu_flags[F_Z];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_inc      = 1'b0;
    ir_load      = 1'b0;
    mux_a_sel    = A_REG;
    mux_b_sel    = B_REG;
    alu_op_sel   = ALU_EXT;
    instr_type   = IT_RR;
    rf_we        = 1'b0;
    rf_data_sel  = RD_ALU;
    pc_en        = 1'b0;
    pc_sel       = PC_INC;
    mem_addr_sel = MA_PC;
    mem_we       = 1'b0;
    illegal      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (last_lat) begin
          ir_load = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_load, is_stor: state_d = S_MEM;
          is_exec:          state_d = S_EXEC;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (1'b1)
          is_rr: rf_we = (ext != EXT_CMP);
          is_imm: begin
            alu_op_sel = ALU_OP;
            instr_type = IT_IMM;
            mux_b_sel  = is_sext_op(op) ? B_SEXT : B_ZEXT;
            rf_we      = (op != OP_CMPI);
          end
          is_lui: begin
            rf_we       = 1'b1;
            rf_data_sel = RD_LUI;
          end
          is_bcond: if (taken) begin
            mux_a_sel  = A_PC;
            mux_b_sel  = B_SEXT;
            instr_type = IT_BR;
            pc_en      = 1'b1;
            pc_sel     = PC_ALU;
          end
          is_jcond: if (taken) begin
            pc_en  = 1'b1;
            pc_sel = PC_REG;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // first MEM cycle only lets the B-reg address settle
        mem_addr_sel = MA_REG;
        if (armed_q) begin
          if (is_stor) begin
            mem_we = 1'b1;
            if (last_st) state_d = S_FETCH;
            else         cnt_inc = 1'b1;
          end else begin
            state_d = S_LOAD_WAIT;
          end
        end
      end
      S_LOAD_WAIT: begin
        mem_addr_sel = MA_REG;
        if (last_lat) begin
          rf_we       = 1'b1;
          rf_data_sel = RD_MEM;
          state_d     = S_FETCH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      ir_load = 1'b0;
      rf_we   = 1'b0;
      pc_en   = 1'b0;
      mem_we  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_inc)       cnt_d = cnt_q + 1'b1;
  end

  assign armed_d   = (state_q == S_MEM) && (state_d == S_MEM);
  assign flags     = flags_q;
  assign state_dbg = state_q;

endmodule
